// File: rtl/etc_lane_scheduler.sv
// Round-robin scheduler sharing one ETC speed-measurement datapath among NUM_LANES toll lanes.
// Define ETC_SCHED_LANE0_PRIORITY_EN to make lane 0 an emergency lane that always wins arbitration.
module etc_lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_SPEED = 14,
    parameter int SYS_FREQ    = 10000000,
    parameter int TIMEOUT_MS  = 500
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         req,
    output logic [NUM_LANES-1:0]         grant,
    output logic                         dp_start,
    output logic                         dp_abort,
    input  logic                         dp_done,
    input  logic [WIDTH_SPEED-1:0]       dp_speed,
    output logic                         res_valid,
    output logic [$clog2(NUM_LANES)-1:0] res_lane,
    output logic [WIDTH_SPEED-1:0]       res_speed,
    output logic                         res_timeout,
    output logic                         busy
);
    localparam int LANE_W      = $clog2(NUM_LANES);
    localparam int TIMEOUT_CYC = SYS_FREQ / 1000 * TIMEOUT_MS;
    localparam int TIMER_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RUN, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      cur_q, cur_d;
    logic [LANE_W-1:0]      rr_q, rr_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [NUM_LANES-1:0]   grant_q, grant_d;
    logic                   start_q, start_d;
    logic                   abort_q, abort_d;
    logic                   valid_q, valid_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WIDTH_SPEED-1:0] speed_q, speed_d;
    logic                   tmo_q, tmo_d;
    logic                   busy_q, busy_d;

    logic [LANE_W-1:0]      pick;
    int                     idx;

    // Cyclic search from rr_q; scanning downwards leaves the nearest requester in pick.
    always_comb begin
        pick = rr_q;
        idx  = 0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (req[LANE_W'(idx)]) pick = LANE_W'(idx);
        end
`ifdef ETC_SCHED_LANE0_PRIORITY_EN
        if (req[0]) pick = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            timer_q <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            lane_q  <= '0;
            speed_q <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            start_q <= start_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
            speed_q <= speed_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        grant_d = grant_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        valid_d = 1'b0;
        lane_d  = lane_q;
        speed_d = speed_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_d   = pick;
                    grant_d = NUM_LANES'(1) << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // Done beats timeout, which beats the lane withdrawing its request.
                timer_d = timer_q + 1'b1;
                if (dp_done) begin
                    speed_d = dp_speed;
                    tmo_d   = 1'b0;
                    lane_d  = cur_q;
                    valid_d = 1'b1;
                    state_d = RELEASE;
                end else if (timer_q == TIMER_END) begin
                    abort_d = 1'b1;
                    speed_d = '0;
                    tmo_d   = 1'b1;
                    lane_d  = cur_q;
                    valid_d = 1'b1;
                    state_d = RELEASE;
                end else if (!req[cur_q]) begin
                    abort_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
`ifdef ETC_SCHED_LANE0_PRIORITY_EN
                if (cur_q != '0) rr_d = (cur_q == LAST_LANE) ? '0 : cur_q + 1'b1;
`else
                rr_d = (cur_q == LAST_LANE) ? '0 : cur_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign grant       = grant_q;
    assign dp_start    = start_q;
    assign dp_abort    = abort_q;
    assign res_valid   = valid_q;
    assign res_lane    = lane_q;
    assign res_speed   = speed_q;
    assign res_timeout = tmo_q;
    assign busy        = busy_q;

endmodule
